led_sequencer: RTL and testbench

- Parametrised LED pattern sequencer for the PL.
- Drives a one-hot LED bank that steps every STEP_CYCLES clocks.
- Four run-time modes: rotate-left, rotate-right, ping-pong, hold.
- Raises a sticky, ack-cleared interrupt to the PS each time the sequence reaches its terminal position, with overrun detection.

---
 rtl/led_seq_pkg.sv | 19 +
 rtl/step_timer.sv | 38 +++
 rtl/led_sequencer.sv | 139 +++++++++++++
 tb/tb_led_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer.
// Contents:
//   mode_e : run-time pattern mode encodings driven on the mode port
//   dir_e  : ping-pong travel direction
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L    = 2'd0,
    MODE_ROT_R    = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_HOLD     = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/step_timer.sv
// Free-running step timer shared by timed PL blocks.
// Counts clocks while enabled and produces a one-cycle step_tick every
// STEP_CYCLES enabled clocks. While disabled the count is frozen.
// Ports:
//   clk       in  fabric clock
//   rst       in  asynchronous active-high reset
//   enable    in  1 = count, 0 = freeze
//   step_tick out high during the last clock of each step (combinational)
module step_timer #(
  parameter int STEP_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic step_tick
);

  localparam int CNT_W = $clog2(STEP_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The tick is the cycle in which the counter sits on its last value, so
  // whatever consumes it updates on the same edge that wraps the counter.
  assign step_tick = enable && (cnt == LAST_CNT);

  // Counter wraps to zero on the tick and holds whenever enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (step_tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: steps a one-hot LED bank every STEP_CYCLES clocks
// in one of four modes and raises a sticky interrupt at the terminal
// position of the sequence.
// Ports:
//   clk          in  fabric clock
//   rst          in  asynchronous active-high reset
//   enable       in  1 = stepping runs, 0 = counter and position frozen
//   mode         in  0 rotate-left, 1 rotate-right, 2 ping-pong, 3 hold
//   intr_en      in  masks o_intr only; pending is unaffected
//   intr_ack     in  one-cycle pulse clearing pending and overrun
//   led          out one-hot LED drive (registered)
//   position     out index of the lit LED (registered)
//   o_intr       out pending & intr_en (registered)
//   intr_overrun out sticky: terminal event while already pending
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS    = 4,
  parameter int STEP_CYCLES = 25000000,
  localparam int POS_W      = $clog2(NUM_LEDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic                intr_en,
  input  logic                intr_ack,
  output logic [NUM_LEDS-1:0] led,
  output logic [POS_W-1:0]    position,
  output logic                o_intr,
  output logic                intr_overrun
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);

  logic       step_tick;
  mode_e      mode_q;
  dir_e       dir_q;
  logic       pending;

  mode_e             eff_mode;
  dir_e              cur_dir;
  dir_e              dir_next;
  logic [POS_W-1:0]  pos_next;
  logic              term_evt;
  logic              pending_next;
  logic              overrun_next;

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .step_tick(step_tick)
  );

  // Next position, direction and terminal event. The mode seen on the
  // tick cycle governs that step, so the live input is used on a tick and
  // mode_q (only needed to spot a switch into ping-pong) otherwise.
  always_comb begin
    eff_mode = step_tick ? mode_e'(mode) : mode_q;
    cur_dir  = dir_q;
    dir_next = dir_q;
    pos_next = position;
    term_evt = 1'b0;

    if (step_tick) begin
      case (eff_mode)
        MODE_ROT_L: begin
          pos_next = (position == LAST_POS) ? '0 : position + POS_W'(1);
          term_evt = (pos_next == LAST_POS);
        end
        MODE_ROT_R: begin
          pos_next = (position == '0) ? LAST_POS : position - POS_W'(1);
          term_evt = (pos_next == '0);
        end
        MODE_PINGPONG: begin
          // On entry the stale direction is discarded: only the top end
          // forces a downward start.
          if (mode_q != MODE_PINGPONG) begin
            cur_dir = (position == LAST_POS) ? DIR_DOWN : DIR_UP;
          end
          pos_next = (cur_dir == DIR_UP) ? position + POS_W'(1)
                                         : position - POS_W'(1);
          dir_next = cur_dir;
          if (pos_next == LAST_POS) begin
            dir_next = DIR_DOWN;
          end else if (pos_next == '0) begin
            dir_next = DIR_UP;
            term_evt = 1'b1;
          end
        end
        default: begin
          pos_next = position;
        end
      endcase
    end
  end

  // Interrupt bookkeeping. A terminal event beats a coincident ack, and in
  // that case the ack still retires the earlier event, clearing overrun.
  always_comb begin
    pending_next = pending;
    overrun_next = intr_overrun;
    if (term_evt) begin
      pending_next = 1'b1;
      overrun_next = intr_ack ? 1'b0 : (intr_overrun | pending);
    end else if (intr_ack) begin
      pending_next = 1'b0;
      overrun_next = 1'b0;
    end
  end

  // State and output registers; led and o_intr are derived from the next
  // values so they change on the same edge as position and pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= MODE_ROT_L;
      dir_q        <= DIR_UP;
      position     <= '0;
      led          <= NUM_LEDS'(1);
      pending      <= 1'b0;
      o_intr       <= 1'b0;
      intr_overrun <= 1'b0;
    end else begin
      if (step_tick) begin
        mode_q <= mode_e'(mode);
      end
      dir_q        <= dir_next;
      position     <= pos_next;
      led          <= NUM_LEDS'(1) << pos_next;
      pending      <= pending_next;
      o_intr       <= pending_next & intr_en;
      intr_overrun <= overrun_next;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (NUM_LEDS=4, STEP_CYCLES=4).
// A driver issues directed and random stimulus on falling edges, runs a
// behavioural model and queues the expected post-edge outputs; a monitor
// pops one entry after every rising edge and compares.
module tb_led_sequencer;

  localparam int N = 4;
  localparam int S = 4;

  typedef struct packed {
    logic [N-1:0] led;
    logic [1:0]   pos;
    logic         intr;
    logic         ovr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] mode;
  logic       intr_en;
  logic       intr_ack;
  logic [N-1:0] led;
  logic [1:0] position;
  logic       o_intr;
  logic       intr_overrun;

  exp_t exp_q[$];
  int   total_checks = 0;
  int   pass_checks  = 0;
  int   pushed       = 0;
  int   popped       = 0;
  int   cycle        = 0;

  int   m_cnt, m_pos, m_dir, m_last_mode;
  bit   m_pend, m_ovr, m_intr;

  led_sequencer #(
    .NUM_LEDS   (N),
    .STEP_CYCLES(S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .intr_en     (intr_en),
    .intr_ack    (intr_ack),
    .led         (led),
    .position    (position),
    .o_intr      (o_intr),
    .intr_overrun(intr_overrun)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=time limit reached required=summary");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Reference model: positions as plain integers, direction as +1/-1.
  function automatic void modelReset();
    m_cnt = 0; m_pos = 0; m_dir = 1; m_last_mode = 0;
    m_pend = 0; m_ovr = 0; m_intr = 0;
  endfunction

  function automatic void modelStep(input bit r, input bit en,
                                    input int md, input bit ie,
                                    input bit ack);
    bit tick, evt;
    if (r) begin
      modelReset();
      return;
    end
    tick = en && (m_cnt == S - 1);
    evt  = 0;
    if (en) m_cnt = (m_cnt + 1) % S;
    if (tick) begin
      if (md == 0) begin
        m_pos = (m_pos + 1) % N;
        evt = (m_pos == N - 1);
      end else if (md == 1) begin
        m_pos = (m_pos + N - 1) % N;
        evt = (m_pos == 0);
      end else if (md == 2) begin
        if (m_last_mode != 2) m_dir = (m_pos == N - 1) ? -1 : 1;
        m_pos = m_pos + m_dir;
        if (m_pos == N - 1) m_dir = -1;
        if (m_pos == 0) begin
          m_dir = 1;
          evt = 1;
        end
      end
      m_last_mode = md;
    end
    if (evt) begin
      m_ovr  = ack ? 1'b0 : (m_ovr | m_pend);
      m_pend = 1;
    end else if (ack) begin
      m_pend = 0;
      m_ovr  = 0;
    end
    m_intr = m_pend & ie;
  endfunction

  function automatic exp_t modelOut();
    exp_t e;
    e.led  = N'(1) << m_pos;
    e.pos  = 2'(m_pos);
    e.intr = m_intr;
    e.ovr  = m_ovr;
    return e;
  endfunction

  // One comparison per output field against an expected record.
  task automatic checkOutput(input exp_t e, input string tag);
    total_checks++;
    if (led === e.led) pass_checks++;
    else $display("[TB] FAIL %s led: actual=%b required=%b cycle=%0d", tag, led, e.led, cycle);
    total_checks++;
    if (position === e.pos) pass_checks++;
    else $display("[TB] FAIL %s position: actual=%0d required=%0d cycle=%0d", tag, position, e.pos, cycle);
    total_checks++;
    if (o_intr === e.intr) pass_checks++;
    else $display("[TB] FAIL %s o_intr: actual=%b required=%b cycle=%0d", tag, o_intr, e.intr, cycle);
    total_checks++;
    if (intr_overrun === e.ovr) pass_checks++;
    else $display("[TB] FAIL %s intr_overrun: actual=%b required=%b cycle=%0d", tag, intr_overrun, e.ovr, cycle);
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after
  // the following rising edge.
  task automatic applyStimulus(input bit r, input bit en, input bit [1:0] md,
                               input bit ie, input bit ack);
    @(negedge clk);
    rst      = r;
    enable   = en;
    mode     = md;
    intr_en  = ie;
    intr_ack = ack;
    modelStep(r, en, int'(md), ie, ack);
    exp_q.push_back(modelOut());
    pushed++;
  endtask

  // Assert reset away from any clock edge and check that outputs return
  // to reset values before the next rising edge.
  task automatic applyAsyncReset();
    @(negedge clk);
    rst      = 1'b1;
    intr_ack = 1'b0;
    modelStep(1'b1, 1'b0, 0, 1'b0, 1'b0);
    #1;
    checkOutput(modelOut(), "async_reset");
    exp_q.push_back(modelOut());
    pushed++;
  endtask

  // Monitor: every rising edge yields one output sample to check.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        checkOutput(exp_q.pop_front(), "scoreboard");
        popped++;
      end
    end
  end

  initial begin
    bit [1:0] rmode;
    bit       rie;
    modelReset();
    rst = 1'b1; enable = 1'b0; mode = 2'd0; intr_en = 1'b0; intr_ack = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);

    // Rotate-left for six steps, then reset in the middle of a step.
    for (int i = 0; i < 6 * S + 2; i++) applyStimulus(0, 1, 0, 1, 0);
    applyAsyncReset();
    applyStimulus(1, 1, 0, 1, 0);

    // Rotate-left through a wrap, then acknowledge.
    for (int i = 0; i < 5 * S; i++) applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 0);

    // Ping-pong from reset for twelve steps without ack: overrun.
    applyStimulus(1, 0, 2, 1, 0);
    for (int i = 0; i < 12 * S; i++) applyStimulus(0, 1, 2, 1, 0);

    // Rotate-right building overrun, then acks coincident with events.
    for (int i = 0; i < 8 * S; i++) applyStimulus(0, 1, 1, 1, 0);
    for (int i = 0; i < 8 * S; i++)
      applyStimulus(0, 1, 1, 1, (m_cnt == S - 1) && (m_pos == 1));

    // Masked interrupt, unmask, then acknowledge.
    applyStimulus(0, 1, 1, 1, 1);
    for (int i = 0; i < 5 * S; i++) applyStimulus(0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 1, 1, 1, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 1, 0);

    // Freeze with the counter at 2, resume, then switch to hold after a step.
    for (int i = 0; i < 2 * S && m_cnt != 2; i++) applyStimulus(0, 1, 0, 1, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 0);
    for (int i = 0; i < 6 * S; i++) applyStimulus(0, 1, 3, 1, 0);

    // Randomised operation with occasional resets.
    rmode = 2'd2;
    rie   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rmode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  rie   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) begin
        applyAsyncReset();
      end else begin
        applyStimulus($urandom_range(0, 299) == 0,
                      $urandom_range(0, 7) != 0,
                      rmode, rie,
                      $urandom_range(0, 9) == 0);
      end
    end
    applyStimulus(0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    total_checks++;
    if (exp_q.size() == 0 && popped == pushed) pass_checks++;
    else $display("[TB] FAIL drain: actual=%0d popped required=%0d pushed", popped, pushed);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
